// File: rtl/lcd_cmd_seq.sv
// ---------------------------------------------------------------------------
// lcd_cmd_seq
//
// Command sequencer placed directly in front of the LCD image controller.
// The host pushes 4-bit opcodes into a small FIFO. The sequencer issues them
// to the controller one at a time as a single-cycle strobe on cmd/cmd_valid.
// It waits for the controller's busy level before each issue. It also checks
// that the controller acknowledges every issue by raising busy.
//
// Parameters
//   DEPTH : FIFO entries (power of two, >= 2)
//   CW    : width of issued_cnt
//
// Ports
//   clk, reset         : single rising-edge clock, synchronous active-high reset
//   in_valid, in_cmd   : host opcode offer (legal opcodes 0..11)
//   in_ready           : FIFO has room (no pass-through on a same-cycle pop)
//   cmd, cmd_valid     : opcode and one-cycle issue strobe to the controller
//   busy, done         : controller busy level and frame-write-complete pulse
//   fifo_count         : current FIFO occupancy
//   issued_cnt         : commands issued (wraps)
//   frame_cnt          : done pulses seen (wraps)
//   err_opcode         : sticky, an illegal opcode was dropped
//   err_hs             : sticky, controller did not raise busy after an issue
// ---------------------------------------------------------------------------
module lcd_cmd_seq #(
  parameter int DEPTH = 16,
  parameter int CW    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [3:0]               in_cmd,
  output logic                     in_ready,
  output logic [3:0]               cmd,
  output logic                     cmd_valid,
  input  logic                     busy,
  input  logic                     done,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CW-1:0]            issued_cnt,
  output logic [7:0]               frame_cnt,
  output logic                     err_opcode,
  output logic                     err_hs
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam logic [3:0] MAX_LEGAL_OP = 4'd11;

  typedef enum logic [1:0] {
    ST_READY,
    ST_ISSUE,
    ST_ACK,
    ST_EXEC
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t              state_q, state_d;

  logic [3:0]          mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]     count_q, count_d;

  logic [3:0]          cmd_q, cmd_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic [CW-1:0]       issued_q, issued_d;
  logic [7:0]          frame_q, frame_d;
  logic                err_opcode_q, err_opcode_d;
  logic                err_hs_q, err_hs_d;

  // -------------------------------------------------------------------------
  // Push side
  // -------------------------------------------------------------------------
  logic fifo_full;
  logic fifo_empty;
  logic push_hs;      // host handshake completes (legal or not)
  logic push_store;   // handshake with a legal opcode: write into the FIFO
  logic push_drop;    // handshake with an illegal opcode: flag and discard
  logic pop;

  // Readiness depends only on the registered count. A pop in the same cycle
  // does not open a slot early.
  assign fifo_full  = (count_q == CNTW'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign in_ready   = !fifo_full;

  assign push_hs    = in_valid && in_ready;
  assign push_store = push_hs && (in_cmd <= MAX_LEGAL_OP);
  assign push_drop  = push_hs && (in_cmd >  MAX_LEGAL_OP);

  // FIFO storage is never cleared. Reset only moves the pointers, so stale
  // entries stay unreachable until they are overwritten.
  always_ff @(posedge clk) begin
    if (push_store) begin
      mem_q[wr_ptr_q] <= in_cmd;
    end
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    err_opcode_d = err_opcode_q;
    if (push_store) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (push_drop) begin
      err_opcode_d = 1'b1;
    end
  end

  // Occupancy: a simultaneous store and pop leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    unique case ({push_store, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // -------------------------------------------------------------------------
  // Issue FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;          // cmd holds its last issued value
    cmd_valid_d = 1'b0;           // strobe lasts exactly one cycle
    rd_ptr_d    = rd_ptr_q;
    issued_d    = issued_q;
    err_hs_d    = err_hs_q;
    pop         = 1'b0;

    unique case (state_q)
      ST_READY: begin
        // The head is registered straight into cmd. This gives the
        // one-cycle issue latency from the deciding cycle.
        if (!busy && !fifo_empty) begin
          pop         = 1'b1;
          cmd_d       = mem_q[rd_ptr_q];
          cmd_valid_d = 1'b1;
          rd_ptr_d    = rd_ptr_q + 1'b1;
          issued_d    = issued_q + 1'b1;
          state_d     = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // The controller samples the strobe during this cycle.
        state_d = ST_ACK;
      end

      ST_ACK: begin
        // The controller must have raised busy one cycle after sampling.
        // If it did not, the command is lost and is not retried.
        if (busy) begin
          state_d = ST_EXEC;
        end else begin
          err_hs_d = 1'b1;
          state_d  = ST_READY;
        end
      end

      ST_EXEC: begin
        if (!busy) begin
          state_d = ST_READY;
        end
      end

      default: begin
        state_d = ST_READY;
      end
    endcase
  end

  // Frame counter runs independently of the FSM.
  always_comb begin
    frame_d = frame_q;
    if (done) begin
      frame_d = frame_q + 8'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_READY;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      cmd_q        <= 4'd0;
      cmd_valid_q  <= 1'b0;
      issued_q     <= '0;
      frame_q      <= 8'd0;
      err_opcode_q <= 1'b0;
      err_hs_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      cmd_q        <= cmd_d;
      cmd_valid_q  <= cmd_valid_d;
      issued_q     <= issued_d;
      frame_q      <= frame_d;
      err_opcode_q <= err_opcode_d;
      err_hs_q     <= err_hs_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign cmd        = cmd_q;
  assign cmd_valid  = cmd_valid_q;
  assign fifo_count = count_q;
  assign issued_cnt = issued_q;
  assign frame_cnt  = frame_q;
  assign err_opcode = err_opcode_q;
  assign err_hs     = err_hs_q;

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// ---------------------------------------------------------------------------
// tb_lcd_cmd_seq
//
// Directed testbench for lcd_cmd_seq with DEPTH=16 and CW=16.
//
// A small controller model drives busy and done after each strobe. It has
// four modes:
//   0 : busy is driven by hand from the test tasks
//   1 : busy is raised for one cycle after each strobe
//   2 : the strobe is never acknowledged
//   3 : busy is held for 66 cycles, with one done pulse
//
// Outputs are sampled on the falling edge. Inputs change just after that
// sampling point.
// ---------------------------------------------------------------------------
module tb_lcd_cmd_seq;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [3:0]  in_cmd;
  logic        in_ready;
  logic [3:0]  cmd;
  logic        cmd_valid;
  logic        busy_w;
  logic        busy_man;
  logic        busy_model;
  logic        done_model;
  logic [4:0]  fifo_count;
  logic [15:0] issued_cnt;
  logic [7:0]  frame_cnt;
  logic        err_opcode;
  logic        err_hs;

  logic [1:0]  model_mode;
  int          exec_len;
  logic        frame_cmd;

  int          chk;
  int          pass;
  int          cyc;
  int          dbl;
  logic        prev_v;
  logic [3:0]  sq_cmd[$];
  int          sq_cyc[$];

  assign busy_w = (model_mode == 2'd0) ? busy_man : busy_model;

  lcd_cmd_seq #(.DEPTH(16), .CW(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_cmd     (in_cmd),
    .in_ready   (in_ready),
    .cmd        (cmd),
    .cmd_valid  (cmd_valid),
    .busy       (busy_w),
    .done       (done_model),
    .fifo_count (fifo_count),
    .issued_cnt (issued_cnt),
    .frame_cnt  (frame_cnt),
    .err_opcode (err_opcode),
    .err_hs     (err_hs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controller model.
  initial begin
    busy_model = 1'b0;
    done_model = 1'b0;
    exec_len   = 0;
    frame_cmd  = 1'b0;
    forever begin
      @(negedge clk);
      if ((model_mode == 2'd1 || model_mode == 2'd3) && cmd_valid) begin
        exec_len  = (model_mode == 2'd3) ? 66 : 1;
        frame_cmd = (model_mode == 2'd3);
        for (int i = 0; i < exec_len; i++) begin
          @(posedge clk); #1;
          busy_model = 1'b1;
          done_model = frame_cmd && (i == exec_len - 1);
        end
        @(posedge clk); #1;
        busy_model = 1'b0;
        done_model = 1'b0;
      end
    end
  end

  // Advance one clock and sample on the falling edge. Every strobe is logged.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (cmd_valid) begin
      $display("strobe   cyc=%0d cmd=%0d issued=%0d", cyc, cmd, issued_cnt);
      sq_cmd.push_back(cmd);
      sq_cyc.push_back(cyc);
      if (prev_v) dbl++;
    end
    prev_v = cmd_valid;
  endtask

  task automatic push(input logic [3:0] c);
    in_valid = 1'b1;
    in_cmd   = c;
    $display("push     cyc=%0d cmd=%0d ready=%0d", cyc + 1, c, in_ready);
    step();
    in_valid = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_and_issue();
    int d;
    reset = 1'b1; busy_man = 1'b1; model_mode = 2'd0;
    steps(2);
    chk++; if (cmd_valid !== 1'b0) $display("FAIL rst_cmd_valid: got %0d expected 0", cmd_valid); else pass++;
    chk++; if (fifo_count !== 5'd0) $display("FAIL rst_count: got %0d expected 0", fifo_count); else pass++;
    chk++; if (issued_cnt !== 16'd0 || frame_cnt !== 8'd0) $display("FAIL rst_counters: got %0d/%0d expected 0/0", issued_cnt, frame_cnt); else pass++;
    chk++; if (err_opcode !== 1'b0 || err_hs !== 1'b0) $display("FAIL rst_flags: got %0d/%0d expected 0/0", err_opcode, err_hs); else pass++;
    chk++; if (cmd !== 4'd0) $display("FAIL rst_cmd: got %0d expected 0", cmd); else pass++;
    reset = 1'b0;
    step();
    chk++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %0d expected 1", in_ready); else pass++;
    push(4'd1); push(4'd5); push(4'd0);
    steps(66);   // busy has been high for 70 cycles since reset released
    chk++; if (fifo_count !== 5'd3) $display("FAIL t1_queued: got %0d expected 3", fifo_count); else pass++;
    chk++; if (sq_cmd.size() != 0) $display("FAIL t1_no_issue_busy: got %0d strobes expected 0", sq_cmd.size()); else pass++;
    sq_cmd.delete(); sq_cyc.delete();
    model_mode = 2'd1;   // busy falls here
    d = cyc;
    steps(14);
    chk++; if (sq_cmd.size() != 3) $display("FAIL t1_strobe_cnt: got %0d expected 3", sq_cmd.size()); else pass++;
    if (sq_cmd.size() == 3) begin
      chk++; if (sq_cmd[0] !== 4'd1 || sq_cmd[1] !== 4'd5 || sq_cmd[2] !== 4'd0)
        $display("FAIL t1_order: got %0d,%0d,%0d expected 1,5,0", sq_cmd[0], sq_cmd[1], sq_cmd[2]); else pass++;
      chk++; if (sq_cyc[0] != d + 1) $display("FAIL t1_first_latency: got %0d expected %0d", sq_cyc[0], d + 1); else pass++;
      chk++; if (sq_cyc[1] - sq_cyc[0] != 4 || sq_cyc[2] - sq_cyc[1] != 4)
        $display("FAIL t1_spacing: got %0d,%0d expected 4,4", sq_cyc[1] - sq_cyc[0], sq_cyc[2] - sq_cyc[1]); else pass++;
    end
    chk++; if (issued_cnt !== 16'd3 || fifo_count !== 5'd0) $display("FAIL t1_end: got issued=%0d count=%0d expected 3/0", issued_cnt, fifo_count); else pass++;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_illegal_opcode();
    int peak;
    peak = 0;
    busy_man = 1'b1; model_mode = 2'd0;
    push(4'd3);  if (fifo_count > peak) peak = fifo_count;
    push(4'd12); if (fifo_count > peak) peak = fifo_count;
    chk++; if (err_opcode !== 1'b1) $display("FAIL t2_err_set: got %0d expected 1", err_opcode); else pass++;
    chk++; if (fifo_count !== 5'd1) $display("FAIL t2_not_stored: got %0d expected 1", fifo_count); else pass++;
    push(4'd15); if (fifo_count > peak) peak = fifo_count;
    push(4'd4);  if (fifo_count > peak) peak = fifo_count;
    chk++; if (peak != 2) $display("FAIL t2_peak: got %0d expected 2", peak); else pass++;
    sq_cmd.delete(); sq_cyc.delete();
    model_mode = 2'd1;
    steps(12);
    chk++; if (sq_cmd.size() != 2) $display("FAIL t2_strobe_cnt: got %0d expected 2", sq_cmd.size()); else pass++;
    if (sq_cmd.size() == 2) begin
      chk++; if (sq_cmd[0] !== 4'd3 || sq_cmd[1] !== 4'd4) $display("FAIL t2_order: got %0d,%0d expected 3,4", sq_cmd[0], sq_cmd[1]); else pass++;
    end
    chk++; if (err_opcode !== 1'b1) $display("FAIL t2_err_sticky: got %0d expected 1", err_opcode); else pass++;
    chk++; if (issued_cnt !== 16'd5) $display("FAIL t2_issued: got %0d expected 5", issued_cnt); else pass++;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_full_fifo();
    busy_man = 1'b1; model_mode = 2'd0;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        chk++; if (in_ready !== 1'b1) $display("FAIL t3_ready_before_16: got %0d expected 1", in_ready); else pass++;
      end
      push(4'(i % 12));
    end
    chk++; if (in_ready !== 1'b0) $display("FAIL t3_full_ready: got %0d expected 0", in_ready); else pass++;
    chk++; if (fifo_count !== 5'd16) $display("FAIL t3_full_count: got %0d expected 16", fifo_count); else pass++;
    push(4'd7);  // offered while full: must not be accepted
    chk++; if (fifo_count !== 5'd16) $display("FAIL t3_17th_rejected: got %0d expected 16", fifo_count); else pass++;
    sq_cmd.delete(); sq_cyc.delete();
    model_mode = 2'd1;
    step();
    chk++; if (cmd_valid !== 1'b1 || cmd !== 4'd0) $display("FAIL t3_first_pop: got v=%0d cmd=%0d expected 1/0", cmd_valid, cmd); else pass++;
    chk++; if (in_ready !== 1'b1 || fifo_count !== 5'd15) $display("FAIL t3_ready_after_pop: got r=%0d cnt=%0d expected 1/15", in_ready, fifo_count); else pass++;
    steps(70);
    chk++; if (sq_cmd.size() != 16) $display("FAIL t3_strobe_cnt: got %0d expected 16", sq_cmd.size()); else pass++;
    if (sq_cmd.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        chk++; if (sq_cmd[i] !== 4'(i % 12)) $display("FAIL t3_order[%0d]: got %0d expected %0d", i, sq_cmd[i], i % 12); else pass++;
      end
      chk++; if (sq_cyc[15] - sq_cyc[0] != 60) $display("FAIL t3_span: got %0d expected 60", sq_cyc[15] - sq_cyc[0]); else pass++;
    end
    chk++; if (issued_cnt !== 16'd21 || fifo_count !== 5'd0) $display("FAIL t3_end: got issued=%0d count=%0d expected 21/0", issued_cnt, fifo_count); else pass++;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_handshake_error();
    model_mode = 2'd2;
    push(4'd6);
    push(4'd9);   // this step samples the strobe for opcode 6
    chk++; if (cmd_valid !== 1'b1 || cmd !== 4'd6) $display("FAIL t4_strobe: got v=%0d cmd=%0d expected 1/6", cmd_valid, cmd); else pass++;
    step();
    chk++; if (err_hs !== 1'b0) $display("FAIL t4_err_early: got %0d expected 0", err_hs); else pass++;
    step();
    chk++; if (err_hs !== 1'b1) $display("FAIL t4_err_set: got %0d expected 1", err_hs); else pass++;
    step();
    chk++; if (cmd_valid !== 1'b1 || cmd !== 4'd9) $display("FAIL t4_next_issue: got v=%0d cmd=%0d expected 1/9", cmd_valid, cmd); else pass++;
    steps(5);
    chk++; if (issued_cnt !== 16'd23 || fifo_count !== 5'd0) $display("FAIL t4_end: got issued=%0d count=%0d expected 23/0", issued_cnt, fifo_count); else pass++;
    chk++; if (err_hs !== 1'b1) $display("FAIL t4_err_sticky: got %0d expected 1", err_hs); else pass++;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_frame_write();
    model_mode = 2'd3;
    sq_cmd.delete(); sq_cyc.delete();
    push(4'd0);
    push(4'd2);   // this step samples the strobe for opcode 0
    chk++; if (frame_cnt !== 8'd0) $display("FAIL t5_frame_before: got %0d expected 0", frame_cnt); else pass++;
    steps(80);
    chk++; if (sq_cmd.size() != 2) $display("FAIL t5_strobe_cnt: got %0d expected 2", sq_cmd.size()); else pass++;
    if (sq_cmd.size() == 2) begin
      chk++; if (sq_cmd[0] !== 4'd0 || sq_cmd[1] !== 4'd2) $display("FAIL t5_order: got %0d,%0d expected 0,2", sq_cmd[0], sq_cmd[1]); else pass++;
      chk++; if (sq_cyc[1] - sq_cyc[0] != 69) $display("FAIL t5_wait_busy: got %0d expected 69", sq_cyc[1] - sq_cyc[0]); else pass++;
    end
    chk++; if (frame_cnt !== 8'd1) $display("FAIL t5_frame_one: got %0d expected 1", frame_cnt); else pass++;
    chk++; if (cmd_valid !== 1'b0 || cmd !== 4'd2) $display("FAIL t5_cmd_hold: got v=%0d cmd=%0d expected 0/2", cmd_valid, cmd); else pass++;
    steps(75);
    chk++; if (frame_cnt !== 8'd2) $display("FAIL t5_frame_two: got %0d expected 2", frame_cnt); else pass++;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_mid_issue();
    int n;
    busy_man = 1'b1; model_mode = 2'd0;
    for (int i = 1; i <= 6; i++) push(4'(i));
    busy_man = 1'b0;
    step();
    chk++; if (cmd_valid !== 1'b1 || fifo_count !== 5'd5) $display("FAIL t6_in_issue: got v=%0d cnt=%0d expected 1/5", cmd_valid, fifo_count); else pass++;
    reset = 1'b1;
    step();
    chk++; if (cmd_valid !== 1'b0 || fifo_count !== 5'd0) $display("FAIL t6_dropped: got v=%0d cnt=%0d expected 0/0", cmd_valid, fifo_count); else pass++;
    chk++; if (issued_cnt !== 16'd0 || frame_cnt !== 8'd0) $display("FAIL t6_counters: got %0d/%0d expected 0/0", issued_cnt, frame_cnt); else pass++;
    chk++; if (err_opcode !== 1'b0 || err_hs !== 1'b0) $display("FAIL t6_flags: got %0d/%0d expected 0/0", err_opcode, err_hs); else pass++;
    chk++; if (cmd !== 4'd0) $display("FAIL t6_cmd: got %0d expected 0", cmd); else pass++;
    reset = 1'b0;
    n = sq_cmd.size();
    step();
    chk++; if (in_ready !== 1'b1) $display("FAIL t6_ready: got %0d expected 1", in_ready); else pass++;
    steps(8);
    chk++; if (sq_cmd.size() != n) $display("FAIL t6_queue_discarded: got %0d strobes expected 0", sq_cmd.size() - n); else pass++;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_back_to_back();
    chk++; if (dbl != 0) $display("FAIL no_double_strobe: got %0d expected 0", dbl); else pass++;
  endtask

  initial begin
    chk = 0; pass = 0; cyc = 0; dbl = 0; prev_v = 1'b0;
    reset = 1'b1; in_valid = 1'b0; in_cmd = 4'd0;
    busy_man = 1'b1; model_mode = 2'd0;
    test_reset_and_issue();
    test_illegal_opcode();
    test_full_fifo();
    test_handshake_error();
    test_frame_write();
    test_reset_mid_issue();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule

// File: doc/lcd_cmd_seq.md
# lcd_cmd_seq

Command sequencer sitting directly upstream of the LCD image controller. It buffers 4-bit opcodes pushed by the host or testbench in a small FIFO and issues them one at a time on the controller's `cmd`/`cmd_valid` port, honouring the controller's `busy` level. It filters illegal opcodes, checks the controller's handshake, and counts issued commands and completed frame writes.

## Interface

**Parameters**
- `DEPTH`, default 16: FIFO entries; must be a power of two, ≥2.
- `CW`, default 16: width of `issued_cnt`.

**Ports**
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `in_valid`, in, 1: host offers an opcode.
- `in_cmd`, in, 4: opcode; legal values 0–11.
- `in_ready`, out, 1: FIFO can accept.
- `cmd`, out, 4: opcode to the controller.
- `cmd_valid`, out, 1: one-cycle issue strobe.
- `busy`, in, 1: controller busy level.
- `done`, in, 1: controller frame-write-complete pulse.
- `fifo_count`, out, $clog2(DEPTH)+1: current FIFO occupancy.
- `issued_cnt`, out, CW: number of commands issued; wraps.
- `frame_cnt`, out, 8: number of `done` pulses seen; wraps.
- `err_opcode`, out, 1: sticky flag, illegal opcode dropped.
- `err_hs`, out, 1: sticky flag, controller did not acknowledge an issue.

## Operation

**Push**
- `in_ready = (fifo_count != DEPTH)`. There is no pass-through: a pop in the same cycle does not raise `in_ready`.
- A push occurs when `in_valid && in_ready`.
- If `in_cmd` ≤ 11, the opcode is written at the write pointer and the pointer advances.
- If `in_cmd` is 12–15, the opcode is not stored, no pointer moves, and `err_opcode` is set. The handshake still completes.

**Pointers and occupancy**
- Read and write pointers are $clog2(DEPTH) bits and wrap naturally.
- `fifo_count` updates as +1 on push, −1 on pop, and is unchanged on simultaneous push and pop.

**FSM states:** READY, ISSUE, ACK, EXEC.
- **READY:** if `busy == 0` and the FIFO is non-empty:
  - register `cmd` ← head of FIFO and `cmd_valid` ← 1;
  - pop the FIFO;
  - increment `issued_cnt`;
  - go to ISSUE.
  
  Otherwise stay in READY.
- **ISSUE:** `cmd_valid` is high for exactly this cycle, and the controller samples it here. Clear `cmd_valid`; go to ACK.
- **ACK:** if `busy == 1`, go to EXEC. If `busy == 0`, set `err_hs` and go to READY; the command is lost and not retried.
- **EXEC:** wait while `busy == 1`. When `busy == 0`, go to READY.
- No opcode-dependent behaviour. All opcodes, including write (0), go through the same path.
- On every cycle with `done == 1`, `frame_cnt` increments, independent of state.
- `cmd` holds its last issued value between issues.

**Reset** (synchronous, takes priority over everything else)
- FSM goes to READY.
- FIFO is emptied: pointers 0, `fifo_count` 0.
- `cmd` = 0, `cmd_valid` = 0, `issued_cnt` = 0, `frame_cnt` = 0, `err_opcode` = 0, `err_hs` = 0.
- `in_ready` = 1 in the cycle after reset deasserts.
- FIFO contents are not cleared.
- Reset mid-issue drops `cmd_valid` at the next edge; queued opcodes are discarded.

## Timing

- **Issue latency:** FIFO non-empty and `busy` low in cycle N → `cmd_valid` high in cycle N+1.
- An opcode pushed in cycle N is visible to READY in N+1, so the earliest `cmd_valid` is N+2.
- The controller raises `busy` in the cycle after it samples `cmd_valid`. ACK therefore expects `busy` = 1 one cycle after ISSUE.
- **Minimum spacing:** consecutive issues are 4 cycles apart for a 1-cycle controller command (ISSUE, ACK, EXEC seeing `busy` low, READY). Longer commands stretch EXEC.
- After controller reset, `busy` stays high during the image load. READY waits for it; the first issue occurs the cycle after `busy` falls.
- `cmd_valid` never asserts while `busy` was high in the deciding cycle.
- `cmd_valid` is never high for two consecutive cycles.

## Test plan

1. **Reset, then push with controller idle.** Hold `busy` = 1 for 70 cycles after reset, then drop it; push opcodes 1, 5, 0 while `busy` is high. → `cmd_valid` strobes with `cmd` = 1, 5, 0 in that order. The first strobe is 1 cycle after `busy` falls. `issued_cnt` = 3 and `fifo_count` = 0 at the end.
2. **Illegal opcode filtering.** Push 3, 12, 15, 4. → Only 3 and 4 are issued. `err_opcode` = 1 and stays set. `fifo_count` peaks at 2.
3. **Full FIFO.** With `busy` held at 1, push 17 opcodes into `DEPTH` = 16. → `in_ready` = 0 after the 16th push; the 17th is not accepted; `fifo_count` = 16. Release `busy` → 16 strobes follow and `in_ready` returns to 1 after the first pop.
4. **Handshake error.** Controller model never raises `busy` after a strobe. → `err_hs` = 1 two cycles after the strobe, FSM returns to READY, and the next queued opcode is issued.
5. **Frame write.** Issue opcode 0. Model holds `busy` for 66 cycles and pulses `done` once. → `frame_cnt` = 1, and the next strobe occurs only after `busy` falls.
6. **Reset mid-operation.** Assert `reset` during ISSUE with 5 entries queued. → Next cycle: `cmd_valid` = 0, `fifo_count` = 0, all counters and flags = 0.
